// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : if_fetch_stage_pkg                                               |
// | Purpose : Shared types and constants for the instruction-fetch stage:      |
// |           fetch-state encoding, datapath width, reset PC and bubble        |
// |           instruction defaults, and the sequential-PC helper.              |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package if_fetch_stage_pkg;

   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,   // allowed to issue a fetch
      ST_WAIT = 2'd1,   // one request outstanding, waiting for rvalid
      ST_HOLD = 2'd2    // response parked in the skid entry while ID is frozen
   } fetch_state_e;

   // Sequential address; wraps silently at 2^32.
   function automatic logic [INSTR_W-1:0] next_pc(input logic [INSTR_W-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : if_fetch_stage_if                                              |
// | Purpose   : Instruction-memory request/response bus.                       |
// |   imem_req    fetch request valid             (master -> slave)            |
// |   imem_addr   fetch address                   (master -> slave)            |
// |   imem_ready  slave accepts request this cycle (slave -> master)           |
// |   imem_rvalid read data valid                 (slave -> master)            |
// |   imem_rdata  fetched instruction             (slave -> master)            |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface if_fetch_stage_if;
   import if_fetch_stage_pkg::*;

   logic               imem_req;
   logic [INSTR_W-1:0] imem_addr;
   logic               imem_ready;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface
`default_nettype wire

// File: rtl/if_fetch_stage_if_id_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : if_fetch_stage_if_id_buffer                                      |
// | Purpose : IF/ID pipeline register with a one-entry skid (hold) buffer.     |
// |   clock, reset   clock / synchronous active-high reset                     |
// |   freez          ID stall: keep outputs unchanged                          |
// |   flush          redirect: outputs become a bubble, skid entry cleared     |
// |   load_new       load new_instr/new_pc straight into the outputs           |
// |   store_hold     park new_instr/new_pc in the skid entry                   |
// |   release_hold   move the skid entry into the outputs                      |
// |   instruction, pc, valid   IF/ID register outputs                          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module if_fetch_stage_if_id_buffer
   import if_fetch_stage_pkg::*;
#(
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               freez,
   input  logic               flush,
   input  logic               load_new,
   input  logic               store_hold,
   input  logic               release_hold,
   input  logic [INSTR_W-1:0] new_instr,
   input  logic [INSTR_W-1:0] new_pc,
   output logic [INSTR_W-1:0] instruction,
   output logic [INSTR_W-1:0] pc,
   output logic               valid
);

   logic [INSTR_W-1:0] instr_d, instr_q;
   logic [INSTR_W-1:0] pc_d, pc_q;
   logic               valid_d, valid_q;
   logic [INSTR_W-1:0] hold_instr_d, hold_instr_q;
   logic [INSTR_W-1:0] hold_pc_d, hold_pc_q;
   logic               hold_valid_d, hold_valid_q;

   always_comb begin
      instr_d      = instr_q;
      pc_d         = pc_q;
      valid_d      = valid_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      hold_valid_d = hold_valid_q;

      if (flush) begin
         // Bubble keeps the last PC; only instruction and valid change.
         instr_d      = NOP_INSTR;
         valid_d      = 1'b0;
         hold_valid_d = 1'b0;
      end else if (load_new) begin
         instr_d = new_instr;
         pc_d    = new_pc;
         valid_d = 1'b1;
      end else if (release_hold) begin
         instr_d      = hold_instr_q;
         pc_d         = hold_pc_q;
         valid_d      = hold_valid_q;
         hold_valid_d = 1'b0;
      end else begin
         if (store_hold) begin
            hold_instr_d = new_instr;
            hold_pc_d    = new_pc;
            hold_valid_d = 1'b1;
         end
         // Nothing new for ID this cycle: present a bubble unless ID is frozen.
         if (!freez) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         instr_q      <= NOP_INSTR;
         pc_q         <= '0;
         valid_q      <= 1'b0;
         hold_instr_q <= NOP_INSTR;
         hold_pc_q    <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         valid_q      <= valid_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   assign instruction = instr_q;
   assign pc          = pc_q;
   assign valid       = valid_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : if_fetch_stage                                                   |
// | Purpose : Instruction-fetch stage. Owns the PC, issues one-outstanding     |
// |           fetches, buffers the response and drives the IF/ID register.     |
// |   clock, reset   clock / synchronous active-high reset                     |
// |   freez          ID hazard stall                                           |
// |   branch_taken   EXE redirect (priority over all but reset)                |
// |   branch_addr    redirect target                                           |
// |   imem           instruction-memory bus (master side)                      |
// |   instruction    IF/ID instruction                                         |
// |   PC             IF/ID PC (fetch address + 4)                              |
// |   if_valid       IF/ID holds a real instruction                            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   freez,
   input  logic                   branch_taken,
   input  logic [INSTR_W-1:0]     branch_addr,
   if_fetch_stage_if.master       imem,
   output logic [INSTR_W-1:0]     instruction,
   output logic [INSTR_W-1:0]     PC,
   output logic                   if_valid
);

   fetch_state_e       state_d, state_q;
   logic [INSTR_W-1:0] pc_reg_d, pc_reg_q;
   logic [INSTR_W-1:0] fetch_addr_d, fetch_addr_q;
   logic               squash_d, squash_q;

   logic               flush;
   logic               load_new;
   logic               store_hold;
   logic               release_hold;

   assign imem.imem_req  = (state_q == ST_REQ) && !branch_taken;
   assign imem.imem_addr = pc_reg_q;

   always_comb begin
      state_d      = state_q;
      pc_reg_d     = pc_reg_q;
      fetch_addr_d = fetch_addr_q;
      squash_d     = squash_q;
      flush        = 1'b0;
      load_new     = 1'b0;
      store_hold   = 1'b0;
      release_hold = 1'b0;

      if (branch_taken) begin
         pc_reg_d = branch_addr;
         flush    = 1'b1;
         case (state_q)
            ST_WAIT: begin
               if (imem.imem_rvalid) begin
                  // The in-flight response lands now: drop it, nothing left to squash.
                  squash_d = 1'b0;
                  state_d  = ST_REQ;
               end else begin
                  // Response still in flight; a repeated branch leaves squash set.
                  squash_d = 1'b1;
               end
            end
            default: state_d = ST_REQ;
         endcase
      end else begin
         case (state_q)
            ST_REQ: begin
               if (imem.imem_ready) begin
                  fetch_addr_d = pc_reg_q;
                  pc_reg_d     = next_pc(pc_reg_q);
                  state_d      = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem.imem_rvalid) begin
                  state_d = ST_REQ;
                  if (squash_q) begin
                     squash_d = 1'b0;
                  end else if (!freez) begin
                     load_new = 1'b1;
                  end else begin
                     store_hold = 1'b1;
                     state_d    = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!freez) begin
                  release_hold = 1'b1;
                  state_d      = ST_REQ;
               end
            end
            default: state_d = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_REQ;
         pc_reg_q     <= RESET_PC;
         fetch_addr_q <= RESET_PC;
         squash_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_reg_q     <= pc_reg_d;
         fetch_addr_q <= fetch_addr_d;
         squash_q     <= squash_d;
      end
   end

   if_fetch_stage_if_id_buffer #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_buffer (
      .clock        (clock),
      .reset        (reset),
      .freez        (freez),
      .flush        (flush),
      .load_new     (load_new),
      .store_hold   (store_hold),
      .release_hold (release_hold),
      .new_instr    (imem.imem_rdata),
      .new_pc       (next_pc(fetch_addr_q)),
      .instruction  (instruction),
      .pc           (PC),
      .valid        (if_valid)
   );

endmodule
`default_nettype wire
